// File: rtl/cccp_preprocess_pkg.sv
// Shared CCDN constants: the CCCP EtherType and the field positions of the
// CCCP name / version words inside a 64-bit packet word.
package cccp_preprocess_pkg;

   localparam logic [15:0] CCDN_CCCP_ETHERTYPE = 16'h88B6;
   localparam int          CCDN_FIELD_W        = 16;

   // EtherType sits in the second Ethernet word
   localparam int CCDN_ETYPE_LSB   = 16;
   // name[31:16] follows the EtherType in the same word
   localparam int CCDN_NAME_HI_LSB = 0;
   // name[15:0] and version number open the third word
   localparam int CCDN_NAME_LO_LSB = 48;
   localparam int CCDN_NAME_VN_LSB = 32;

   // Pull the EtherType field out of a packet word
   function automatic logic [CCDN_FIELD_W-1:0] ccdn_etype(input logic [63:0] w);
      return w[CCDN_ETYPE_LSB +: CCDN_FIELD_W];
   endfunction

endpackage

// File: rtl/cccp_preprocess.sv
// CCCP pre-processor: passes the packet stream through with one cycle of
// latency and flags the words carrying the CCCP name / version fields,
// keeping per-class packet counters.
module cccp_preprocess
   import cccp_preprocess_pkg::*;
#(
   parameter int          DATA_WIDTH     = 64,
   parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
   parameter logic [15:0] CCCP_ETHERTYPE = CCDN_CCCP_ETHERTYPE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   output logic                  word_CCCP_NAME_HI,
   output logic                  word_CCCP_NAME_LO,
   output logic                  word_CCCP_NAME_VN,
   output logic                  is_cccp,
   output logic [31:0]           cccp_pkt_cnt,
   output logic [31:0]           other_pkt_cnt
);

   // Parser states; WORD1 is kept for encoding compatibility but never entered
   typedef enum logic [2:0] {
      ST_MOD_HDRS = 3'd0,
      ST_WORD1    = 3'd1,
      ST_WORD2    = 3'd2,
      ST_WORD3    = 3'd3,
      ST_PAYLOAD  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic [CTRL_WIDTH-1:0]   out_ctrl_q;
   logic                    out_wr_q;
   logic                    name_hi_q, name_hi_d;
   logic                    name_lo_q, name_lo_d;
   logic                    is_cccp_q, is_cccp_d;
   logic [31:0]             cccp_cnt_q, cccp_cnt_d;
   logic [31:0]             other_cnt_q, other_cnt_d;

   logic accept;
   logic is_ctrl;
   logic eop;

   assign in_rdy  = out_rdy;
   assign accept  = in_wr && out_rdy;
   assign is_ctrl = |in_ctrl;

   // Next-state, strobe and counter decode; everything advances only on accepted words
   always_comb begin
      state_d     = state_q;
      name_hi_d   = 1'b0;
      name_lo_d   = 1'b0;
      is_cccp_d   = is_cccp_q;
      cccp_cnt_d  = cccp_cnt_q;
      other_cnt_d = other_cnt_q;
      eop         = 1'b0;
      if (accept) begin
         case (state_q)
            ST_MOD_HDRS: if (!is_ctrl) state_d = ST_WORD2;
            // WORD1 falls through to WORD2 handling
            ST_WORD1, ST_WORD2: begin
               if (is_ctrl) begin
                  eop     = 1'b1;
                  state_d = ST_MOD_HDRS;
               end else begin
                  state_d = ST_WORD3;
                  if (ccdn_etype(64'(in_data)) == CCCP_ETHERTYPE) begin
                     name_hi_d = 1'b1;
                     is_cccp_d = 1'b1;
                  end
               end
            end
            ST_WORD3: begin
               if (is_ctrl) begin
                  eop     = 1'b1;
                  state_d = ST_MOD_HDRS;
               end else begin
                  state_d   = ST_PAYLOAD;
                  name_lo_d = is_cccp_q;
               end
            end
            ST_PAYLOAD: begin
               if (is_ctrl) begin
                  eop     = 1'b1;
                  state_d = ST_MOD_HDRS;
               end
            end
            default: state_d = ST_MOD_HDRS;
         endcase
      end
      // Runt or normal EOP: close the packet and bill it to its class
      if (eop) begin
         is_cccp_d = 1'b0;
         if (is_cccp_q) cccp_cnt_d  = cccp_cnt_q + 32'd1;
         else           other_cnt_d = other_cnt_q + 32'd1;
      end
   end

   // Pipeline register, FSM and counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_MOD_HDRS;
         out_data_q  <= '0;
         out_ctrl_q  <= '0;
         out_wr_q    <= 1'b0;
         name_hi_q   <= 1'b0;
         name_lo_q   <= 1'b0;
         is_cccp_q   <= 1'b0;
         cccp_cnt_q  <= '0;
         other_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= in_data;
         out_ctrl_q  <= in_ctrl;
         out_wr_q    <= accept;
         name_hi_q   <= name_hi_d;
         name_lo_q   <= name_lo_d;
         is_cccp_q   <= is_cccp_d;
         cccp_cnt_q  <= cccp_cnt_d;
         other_cnt_q <= other_cnt_d;
      end
   end

   assign out_data          = out_data_q;
   assign out_ctrl          = out_ctrl_q;
   assign out_wr            = out_wr_q;
   assign word_CCCP_NAME_HI = name_hi_q;
   assign word_CCCP_NAME_LO = name_lo_q;
   assign word_CCCP_NAME_VN = name_lo_q;
   assign is_cccp           = is_cccp_q;
   assign cccp_pkt_cnt      = cccp_cnt_q;
   assign other_pkt_cnt     = other_cnt_q;

endmodule
